// File: rtl/fetch.sv
// Instruction fetch stage: one outstanding request, a single-entry HOLD buffer
// for decode back-pressure, and DROP handling for requests made stale by a redirect.
// Optional performance counters are enabled by defining FETCH_PERF_EN.

package fetch_pkg;
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] raw_instr;
  } fetch_data_t;
endpackage

module fetch
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        dataF_valid,
  output fetch_data_t dataF
`ifdef FETCH_PERF_EN
  ,
  output logic [63:0] perf_fetched,
  output logic [63:0] perf_stall
`endif
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DROP  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] target_q, target_d;
  logic [31:0] buf_q, buf_d;
  fetch_data_t dataf_q, dataf_d;
  logic        dataf_valid_q, dataf_valid_d;
  logic        ireq_valid_q, ireq_valid_d;

  logic        resp_ok_s;
  logic [63:0] redirect_tgt_s;
  logic        load_s;
  logic [31:0] load_word_s;

  // A response only belongs to us once the request has actually been presented.
  assign resp_ok_s      = iresp_data_ok & ireq_valid_q;
  assign redirect_tgt_s = {redirect_pc[63:2], 2'b00};

  // Next-state, PC, buffer and dataF computation.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    target_d    = target_q;
    buf_d       = buf_q;
    load_s      = 1'b0;
    load_word_s = iresp_data;

    case (state_q)
      ST_FETCH: begin
        if (redirect_valid) begin
          if (resp_ok_s || !ireq_valid_q) begin
            pc_d = redirect_tgt_s;
          end else begin
            target_d = redirect_tgt_s;
            state_d  = ST_DROP;
          end
        end else if (resp_ok_s) begin
          if (stall) begin
            buf_d   = iresp_data;
            state_d = ST_HOLD;
          end else begin
            load_s      = 1'b1;
            load_word_s = iresp_data;
          end
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          pc_d    = redirect_tgt_s;
          buf_d   = 32'd0;
          state_d = ST_FETCH;
        end else if (!stall) begin
          load_s      = 1'b1;
          load_word_s = buf_q;
          state_d     = ST_FETCH;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_DROP: begin
        if (redirect_valid) begin
          if (resp_ok_s) begin
            pc_d    = redirect_tgt_s;
            state_d = ST_FETCH;
          end else begin
            target_d = redirect_tgt_s;
          end
        end else if (resp_ok_s) begin
          pc_d    = target_q;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_DROP;
        end
      end
      default: begin
        pc_d    = RESET_PC;
        state_d = ST_FETCH;
      end
    endcase

    dataf_d       = dataf_q;
    dataf_valid_d = stall ? dataf_valid_q : 1'b0;
    if (redirect_valid) begin
      dataf_valid_d = 1'b0;
    end else if (load_s) begin
      dataf_d.pc        = pc_q;
      dataf_d.raw_instr = load_word_s;
      dataf_valid_d     = 1'b1;
      pc_d              = pc_q + 64'd4;
    end else begin
      dataf_d = dataf_q;
    end

    ireq_valid_d = (state_d != ST_HOLD);
  end

  // Pipeline state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_FETCH;
      pc_q          <= RESET_PC;
      target_q      <= 64'd0;
      buf_q         <= 32'd0;
      dataf_q       <= '0;
      dataf_valid_q <= 1'b0;
      ireq_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      target_q      <= target_d;
      buf_q         <= buf_d;
      dataf_q       <= dataf_d;
      dataf_valid_q <= dataf_valid_d;
      ireq_valid_q  <= ireq_valid_d;
    end
  end

  assign ireq_valid  = ireq_valid_q;
  assign ireq_addr   = pc_q;
  assign dataF_valid = dataf_valid_q;
  assign dataF       = dataf_q;

`ifdef FETCH_PERF_EN
  logic [63:0] perf_fetched_q, perf_fetched_d;
  logic [63:0] perf_stall_q, perf_stall_d;

  // Counters wrap naturally at 2^64.
  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_stall_d   = perf_stall_q;
    if (load_s && !redirect_valid) begin
      perf_fetched_d = perf_fetched_q + 64'd1;
    end else begin
      perf_fetched_d = perf_fetched_q;
    end
    if (state_q == ST_HOLD) begin
      perf_stall_d = perf_stall_q + 64'd1;
    end else begin
      perf_stall_d = perf_stall_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched_q <= 64'd0;
      perf_stall_q   <= 64'd0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch.sv
// Directed self-checking bench for the fetch stage; inputs change and outputs
// are sampled on the falling clock edge.

module tb_fetch;
  import fetch_pkg::*;

  logic        clk;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        stall;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        dataf_valid;
  fetch_data_t dataf;
`ifdef FETCH_PERF_EN
  logic [63:0] perf_fetched;
  logic [63:0] perf_stall;
`endif

  int n_total = 0;
  int n_bad   = 0;

  fetch #(.RESET_PC(64'h8000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .ireq_valid     (ireq_valid),
    .ireq_addr      (ireq_addr),
    .iresp_data_ok  (iresp_data_ok),
    .iresp_data     (iresp_data),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dataF_valid    (dataf_valid),
    .dataF          (dataf)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply inputs, let one rising edge consume them, return at the next falling edge.
  task automatic drive(input logic ok, input logic [31:0] d, input logic st,
                       input logic rv, input logic [63:0] rpc);
    iresp_data_ok  = ok;
    iresp_data     = d;
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 64'd0);
    reset = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 64'd0);
  endtask

  initial begin
    reset          = 1'b1;
    iresp_data_ok  = 1'b0;
    iresp_data     = 32'd0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'd0;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 64'd0);
    drive(1'b0, 32'd0, 1'b0, 1'b0, 64'd0);

    check("rst_ireq_valid", 64'(ireq_valid), 64'd0);
    check("rst_dataf_valid", 64'(dataf_valid), 64'd0);
    check("rst_dataf_pc", dataf.pc, 64'd0);
    check("rst_dataf_raw", 64'(dataf.raw_instr), 64'd0);
    check("rst_ireq_addr", ireq_addr, 64'h8000_0000);

    // Stray data_ok before the first request is raised must be ignored.
    reset = 1'b0;
    drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 64'd0);
    check("first_ireq_valid", 64'(ireq_valid), 64'd1);
    check("first_ireq_addr", ireq_addr, 64'h8000_0000);
    check("early_ok_ignored", 64'(dataf_valid), 64'd0);

    // Streaming with data_ok every cycle.
    drive(1'b1, 32'h0000_0013, 1'b0, 1'b0, 64'd0);
    check("stream0_pc", dataf.pc, 64'h8000_0000);
    check("stream0_valid", 64'(dataf_valid), 64'd1);
    check("stream0_raw", 64'(dataf.raw_instr), 64'h13);
    drive(1'b1, 32'h0000_0013, 1'b0, 1'b0, 64'd0);
    check("stream1_pc", dataf.pc, 64'h8000_0004);
    drive(1'b1, 32'h0000_0013, 1'b0, 1'b0, 64'd0);
    check("stream2_pc", dataf.pc, 64'h8000_0008);
    check("stream2_valid", 64'(dataf_valid), 64'd1);

    // Stall on the response for 0x8000_0004, held for three cycles.
    do_reset();
    drive(1'b1, 32'h0000_00A0, 1'b0, 1'b0, 64'd0);
    check("pre_hold_pc", dataf.pc, 64'h8000_0000);
    drive(1'b1, 32'h0000_00A4, 1'b1, 1'b0, 64'd0);
    check("hold0_ireq_valid", 64'(ireq_valid), 64'd0);
    check("hold0_dataf_pc", dataf.pc, 64'h8000_0000);
    check("hold0_dataf_valid", 64'(dataf_valid), 64'd1);
    drive(1'b0, 32'd0, 1'b1, 1'b0, 64'd0);
    check("hold1_ireq_valid", 64'(ireq_valid), 64'd0);
    drive(1'b0, 32'd0, 1'b1, 1'b0, 64'd0);
    check("hold2_ireq_valid", 64'(ireq_valid), 64'd0);
    check("hold2_dataf_raw", 64'(dataf.raw_instr), 64'hA0);
    drive(1'b0, 32'd0, 1'b0, 1'b0, 64'd0);
    check("release_pc", dataf.pc, 64'h8000_0004);
    check("release_raw", 64'(dataf.raw_instr), 64'hA4);
    check("release_valid", 64'(dataf_valid), 64'd1);
    check("release_ireq_valid", 64'(ireq_valid), 64'd1);
    check("release_ireq_addr", ireq_addr, 64'h8000_0008);
    drive(1'b0, 32'd0, 1'b0, 1'b0, 64'd0);
    check("bubble_valid", 64'(dataf_valid), 64'd0);

    // Redirect while 0x8000_0008 is outstanding: stale response dropped.
    drive(1'b0, 32'd0, 1'b0, 1'b1, 64'h8000_0100);
    check("drop_addr0", ireq_addr, 64'h8000_0008);
    check("drop_ireq_valid", 64'(ireq_valid), 64'd1);
    check("drop_dataf_valid", 64'(dataf_valid), 64'd0);
    drive(1'b0, 32'd0, 1'b0, 1'b0, 64'd0);
    check("drop_addr1", ireq_addr, 64'h8000_0008);
    drive(1'b1, 32'h0BAD_0BAD, 1'b0, 1'b0, 64'd0);
    check("drop_resp_valid", 64'(dataf_valid), 64'd0);
    check("drop_new_addr", ireq_addr, 64'h8000_0100);
    drive(1'b1, 32'h0000_00C0, 1'b0, 1'b0, 64'd0);
    check("tgt_pc", dataf.pc, 64'h8000_0100);
    check("tgt_raw", 64'(dataf.raw_instr), 64'hC0);
    drive(1'b1, 32'h0000_00C4, 1'b0, 1'b0, 64'd0);
    drive(1'b1, 32'h0000_00C8, 1'b0, 1'b0, 64'd0);
    check("tgt2_pc", dataf.pc, 64'h8000_0108);
`ifdef FETCH_PERF_EN
    check("perf_fetched5", perf_fetched, 64'd5);
    check("perf_stall3", perf_stall, 64'd3);
`endif

    // Redirect + data_ok + stall, misaligned target.
    drive(1'b1, 32'h0000_00CC, 1'b1, 1'b1, 64'h8000_0103);
    check("rdok_dataf_valid", 64'(dataf_valid), 64'd0);
    check("rdok_ireq_addr", ireq_addr, 64'h8000_0100);
    check("rdok_ireq_valid", 64'(ireq_valid), 64'd1);

    // Redirect out of HOLD discards the buffered word.
    drive(1'b1, 32'h0000_00E0, 1'b1, 1'b0, 64'd0);
    check("hold_b_ireq_valid", 64'(ireq_valid), 64'd0);
    drive(1'b0, 32'd0, 1'b1, 1'b1, 64'h8000_0200);
    check("hold_rd_ireq_valid", 64'(ireq_valid), 64'd1);
    check("hold_rd_addr", ireq_addr, 64'h8000_0200);
    check("hold_rd_dataf_valid", 64'(dataf_valid), 64'd0);
    drive(1'b1, 32'h0000_00F0, 1'b0, 1'b0, 64'd0);
    check("hold_rd_next_pc", dataf.pc, 64'h8000_0200);
    check("hold_rd_next_raw", 64'(dataf.raw_instr), 64'hF0);

    // PC wrap at the top of the address space.
    drive(1'b1, 32'd0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_addr", ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    drive(1'b1, 32'h0000_0011, 1'b0, 1'b0, 64'd0);
    check("wrap_dataf_pc", dataf.pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_next_addr", ireq_addr, 64'd0);
    drive(1'b1, 32'h0000_0022, 1'b0, 1'b0, 64'd0);
    check("wrap_zero_pc", dataf.pc, 64'd0);
    check("wrap_addr4", ireq_addr, 64'd4);

    // Second redirect while in DROP overwrites the target.
    drive(1'b0, 32'd0, 1'b0, 1'b1, 64'h1000);
    check("drop2_addr0", ireq_addr, 64'd4);
    drive(1'b0, 32'd0, 1'b0, 1'b1, 64'h2002);
    check("drop2_addr1", ireq_addr, 64'd4);
    drive(1'b1, 32'h0000_0033, 1'b0, 1'b0, 64'd0);
    check("drop2_new_addr", ireq_addr, 64'h2000);
    check("drop2_dataf_valid", 64'(dataf_valid), 64'd0);

    // Reset in the middle of an outstanding request.
    reset = 1'b1;
    drive(1'b1, 32'h0000_0044, 1'b0, 1'b0, 64'd0);
    check("midrst_ireq_valid", 64'(ireq_valid), 64'd0);
    check("midrst_addr", ireq_addr, 64'h8000_0000);
    check("midrst_dataf_valid", 64'(dataf_valid), 64'd0);
`ifdef FETCH_PERF_EN
    check("midrst_perf_fetched", perf_fetched, 64'd0);
    check("midrst_perf_stall", perf_stall, 64'd0);
`endif
    reset = 1'b0;
    drive(1'b1, 32'h0000_0055, 1'b0, 1'b0, 64'd0);
    check("post_rst_late_ok", 64'(dataf_valid), 64'd0);
    check("post_rst_addr", ireq_addr, 64'h8000_0000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h8000_0000, the PC fetched first after reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port ireq_valid, output, 1, instruction request valid.
REQ-005 SHALL have port ireq_addr, output, 64, instruction request address.
REQ-006 SHALL have port iresp_data_ok, input, 1, response data valid this cycle.
REQ-007 SHALL have port iresp_data, input, 32, returned instruction word.
REQ-008 SHALL have port stall, input, 1, decode cannot accept dataF this cycle.
REQ-009 SHALL have port redirect_valid, input, 1, branch/jump redirect request.
REQ-010 SHALL have port redirect_pc, input, 64, redirect target.
REQ-011 SHALL have port dataF_valid, output, 1, dataF holds a live instruction.
REQ-012 SHALL have port dataF, output, fetch_data_t, registered {pc, raw_instr} consumed by decode.

Function
REQ-013 SHALL implement states FETCH (request outstanding), HOLD (instruction buffered, decode stalled), DROP (stale request outstanding after redirect).
REQ-014 ireq_valid SHALL be 1 in FETCH and DROP, 0 in HOLD.
REQ-015 ireq_addr SHALL equal the PC of the outstanding request and stay stable until iresp_data_ok.
REQ-016 FETCH, data_ok, no redirect, no stall: dataF <= {pc, iresp_data}, dataF_valid <= 1, pc <= pc+4, remain FETCH (next request issued next cycle).
REQ-017 FETCH, data_ok, no redirect, stall: iresp_data captured in a buffer, dataF unchanged, go HOLD.
REQ-018 HOLD, no stall, no redirect: dataF <= {pc, buffer}, dataF_valid <= 1, pc <= pc+4, go FETCH.
REQ-019 When stall is 0 and no new instruction is loaded this cycle, dataF_valid SHALL become 0 (bubble); when stall is 1, dataF and dataF_valid SHALL hold.
REQ-020 Redirect SHALL take priority over stall and data_ok: dataF_valid <= 0, any buffered instruction discarded, target pc <= {redirect_pc[63:2], 2'b00}.
REQ-021 Redirect in FETCH without data_ok: go DROP; ireq_addr keeps the old address until data_ok.
REQ-022 Redirect in FETCH coinciding with data_ok: returned data discarded, go FETCH at the new pc next cycle.
REQ-023 Redirect in HOLD: go FETCH at the new pc.
REQ-024 DROP: data_ok discards data and goes FETCH at the saved target; a further redirect in DROP overwrites the target and stays DROP (or goes FETCH if data_ok coincides).
REQ-025 pc+4 SHALL wrap modulo 2^64.
REQ-026 Fetch-to-dataF latency SHALL be one cycle after data_ok when not stalled.

Reset
REQ-027 While reset is high: state FETCH, pc = RESET_PC, dataF_valid = 0, dataF = 0, buffer = 0, ireq_valid = 0.
REQ-028 First cycle after reset deasserts: ireq_valid = 1, ireq_addr = RESET_PC.
REQ-029 Reset mid-request SHALL abandon the request; a late data_ok after reset is treated as the response to the new RESET_PC request only when ireq_valid has been raised.

Configuration
REQ-030 With FETCH_PERF_EN defined, SHALL add outputs perf_fetched (64) counting instructions loaded into dataF and perf_stall (64) counting cycles in HOLD, both reset to 0 and wrapping.
REQ-031 Without FETCH_PERF_EN, those ports and counters SHALL be absent and behaviour otherwise identical.

Verification
REQ-032 Reset release, data_ok every cycle with 0x00000013, no stall -> dataF.pc 0x8000_0000, 0x8000_0004, 0x8000_0008 on consecutive cycles, dataF_valid 1.
REQ-033 data_ok at pc 0x8000_0004 with stall held 3 cycles -> ireq_valid 0 during HOLD, dataF unchanged; after stall drops dataF.pc = 0x8000_0004, then request at 0x8000_0008.
REQ-034 redirect to 0x8000_0100 while request at 0x8000_0008 pending, data_ok 2 cycles later -> ireq_addr stays 0x8000_0008, data discarded, next ireq_addr 0x8000_0100, no dataF_valid for the dropped word.
REQ-035 redirect coinciding with data_ok and stall -> dataF_valid 0 next cycle, ireq_addr = target, stall ignored for redirect.
REQ-036 redirect_pc 0x8000_0103 -> ireq_addr 0x8000_0100; pc 0xFFFF_FFFF_FFFF_FFFC fetched -> next pc 0.
REQ-037 With FETCH_PERF_EN: 5 instructions delivered and 3 HOLD cycles -> perf_fetched 5, perf_stall 3; reset mid-run clears both to 0.
